// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx_serial, samples mid-bit, presents bytes on valid/ready.
// Flags framing errors (stop bit low) and overruns (byte completed while previous unaccepted).
`timescale 1ns/1ps

module uart_rx #(
  parameter int CLKS_PER_BIT = 100,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_serial,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   rx_s;

  state_t        state_q;
  logic [CW-1:0] clk_cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          deliver_q;
  logic [7:0]    rx_data_q;
  logic          rx_valid_q;
  logic          frame_err_q;
  logic          overrun_q;

  // Preset to idle-high so reset release never looks like a start bit.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], rx_serial};
  assign rx_s   = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      deliver_q   <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      deliver_q   <= 1'b0;

      // A completed byte only replaces the held one if it is being accepted this cycle.
      if (deliver_q) begin
        if (!rx_valid_q || rx_ready) begin
          rx_data_q  <= shift_q;
          rx_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          clk_cnt_q <= '0;
          if (!rx_s) begin
            state_q <= START;
          end
        end
        START: begin
          if (clk_cnt_q == CNT_MID) begin
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            state_q   <= rx_s ? IDLE : DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt_q == CNT_LAST) begin
            clk_cnt_q          <= '0;
            shift_q[bit_idx_q] <= rx_s;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (clk_cnt_q == CNT_LAST) begin
            clk_cnt_q <= '0;
            if (rx_s) begin
              deliver_q <= 1'b1;
              state_q   <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= BRK;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        BRK: begin
          // Line held low after a bad stop bit must return high before a new start counts.
          clk_cnt_q <= '0;
          if (rx_s) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed 8N1 scenarios plus randomized frames
// compared against a frame-level model of expected bytes and flag counts.
`timescale 1ns/1ps

module tb_uart_rx;

  localparam int CPB  = 100;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_serial;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_serial (rx_serial),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Monitor state, owned by the monitor processes only.
  logic [7:0] got_q[$];
  int cyc      = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  int both_cnt = 0;
  int vcyc     = 0;
  int rise_cyc = 0;
  logic prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (rx_valid) vcyc++;
    if (rx_valid && !prev_v) rise_cyc = cyc;
    prev_v = rx_valid;
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (frame_err && overrun) both_cnt++;
  end

  // Snapshots taken before each scenario.
  int base, fe0, ov0, v0;
  logic [7:0] exp_q[$];
  int exp_fe;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic snap();
    base = got_q.size();
    fe0  = fe_cnt;
    ov0  = ov_cnt;
    v0   = vcyc;
  endtask

  task automatic send_bit(input logic v);
    rx_serial = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    rx_serial = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_ok);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 rx_ready = v;
    @(negedge clk);
  endtask

  initial begin
    int start_c, lat, nb;
    logic [7:0] b;
    logic bad;
    int gap;

    rx_serial = 1'b1;
    rx_ready  = 1'b1;
    rst_n     = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_data",  rx_data,   8'h00);
    chk("reset_valid", rx_valid,  1'b0);
    chk("reset_ferr",  frame_err, 1'b0);
    chk("reset_ovr",   overrun,   1'b0);
    rst_n = 1'b1;
    idle_bits(1);

    // Single byte 'H'
    snap();
    start_c = cyc;
    send_frame(8'h48, 1'b1);
    idle_bits(1);
    lat = rise_cyc - start_c;
    chk("h_count", got_q.size() - base, 1);
    chk("h_data", got_q[base], 8'h48);
    chk("h_valid_cycles", vcyc - v0, 1);
    chk("h_ferr", fe_cnt - fe0, 0);
    chk("h_ovr", ov_cnt - ov0, 0);
    chk("h_latency", (lat >= SYNC + 9 * CPB + CPB / 2) && (lat <= SYNC + 9 * CPB + CPB / 2 + 5), 1);

    // Back-to-back frames, no idle gap
    snap();
    send_frame(8'h55, 1'b1);
    send_frame(8'hAA, 1'b1);
    idle_bits(1);
    chk("b2b_count", got_q.size() - base, 2);
    chk("b2b_first", got_q[base], 8'h55);
    chk("b2b_second", got_q[base + 1], 8'hAA);
    chk("b2b_ferr", fe_cnt - fe0, 0);

    // Short low glitch on the idle line
    snap();
    rx_serial = 1'b0;
    repeat (20) @(negedge clk);
    idle_bits(2);
    chk("glitch_count", got_q.size() - base, 0);
    chk("glitch_ferr", fe_cnt - fe0, 0);
    chk("glitch_valid", vcyc - v0, 0);
    snap();
    send_frame(8'h5A, 1'b1);
    idle_bits(1);
    chk("glitch_recover", got_q[base], 8'h5A);

    // Stop bit forced low
    snap();
    send_frame(8'h3C, 1'b0);
    idle_bits(1);
    chk("ferr_pulse", fe_cnt - fe0, 1);
    chk("ferr_valid", vcyc - v0, 0);
    chk("ferr_count", got_q.size() - base, 0);
    chk("ferr_ovr", ov_cnt - ov0, 0);

    // Overrun with consumer stalled
    set_ready(1'b0);
    snap();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle_bits(1);
    chk("ovr_pulse", ov_cnt - ov0, 1);
    chk("ovr_ferr", fe_cnt - fe0, 0);
    chk("ovr_valid_held", rx_valid, 1'b1);
    chk("ovr_data_kept", rx_data, 8'h11);
    set_ready(1'b1);
    @(negedge clk);
    chk("ovr_accept_count", got_q.size() - base, 1);
    chk("ovr_accept_data", got_q[base], 8'h11);
    chk("ovr_valid_drop", rx_valid, 1'b0);
    idle_bits(1);

    // Reset during bit 4 of a frame
    snap();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rx_serial = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_data", rx_data, 8'h00);
    chk("midrst_valid", rx_valid, 1'b0);
    chk("midrst_ferr", frame_err, 1'b0);
    chk("midrst_ovr", overrun, 1'b0);
    rx_serial = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    idle_bits(2);
    send_frame(8'h7E, 1'b1);
    idle_bits(1);
    chk("midrst_count", got_q.size() - base, 1);
    chk("midrst_byte", got_q[base], 8'h7E);
    chk("midrst_flag_ferr", fe_cnt - fe0, 0);
    chk("midrst_flag_ovr", ov_cnt - ov0, 0);

    // Randomized frames: good frames yield their byte, bad stop bits yield one frame_err
    snap();
    exp_q.delete();
    exp_fe = 0;
    for (int f = 0; f < 14; f++) begin
      b   = 8'($urandom);
      bad = ($urandom_range(0, 4) == 0);
      gap = $urandom_range(0, 2);
      if (bad && gap == 0) gap = 1;
      send_frame(b, !bad);
      if (bad) exp_fe++;
      else exp_q.push_back(b);
      if (gap > 0) idle_bits(gap);
    end
    idle_bits(1);
    nb = exp_q.size();
    chk("rnd_count", got_q.size() - base, nb);
    for (int i = 0; i < nb; i++) chk("rnd_byte", got_q[base + i], exp_q[i]);
    chk("rnd_ferr", fe_cnt - fe0, exp_fe);
    chk("rnd_ovr", ov_cnt - ov0, 0);

    chk("flags_exclusive", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
